aq_rtu_vpu_wb_buf: RTL and testbench
====================================

Name: aq_rtu_vpu_wb_buf

Overview:
- FIFO buffer between VPU GPR result generation and the RTU writeback stage.
- Absorbs VPU GPR writebacks while writeback port0 is occupied by Rbus. Port0 grants VPU only when no Rbus writeback is valid.
- Drives the VPU request/index/data into writeback port0 in strict FIFO order.
- Raises a starvation flag when the head entry is denied for too long, so upstream can throttle Rbus issue.

Parameters:
- DEPTH, 4: number of buffer entries; must be a power of 2, >= 2.
- PTR_W, 2: pointer width, log2(DEPTH).
- STARVE_LIMIT, 8: consecutive denied cycles before the starve flag is raised; range 1..255.

Ports:
- forever_cpuclk  in  1  core clock, single clock domain
- cpurst  in  1  asynchronous, active-high reset
- vpu_wb_vld  in  1  VPU presents a GPR writeback
- vpu_wb_index  in  6  destination register index
- vpu_wb_data  in  64  writeback data
- wb_buf_vpu_rdy  out  1  buffer can accept a push this cycle
- rtu_vpu_gpr_wb_grnt  in  1  writeback port0 grant to VPU
- vpu_rtu_gpr_wb_req  out  1  head entry requests port0
- vpu_rtu_gpr_wb_index  out  6  head index
- vpu_rtu_gpr_wb_data  out  64  head data
- wb_buf_cnt  out  PTR_W+1  current occupancy
- wb_buf_empty  out  1  no pending entries; RTU uses it as a retire/drain condition
- wb_buf_starve  out  1  head starved for STARVE_LIMIT cycles

Behaviour:
- Interface: one clock, forever_cpuclk. Reset cpurst is asynchronous and active-high.
- Reset values:
  - wr_ptr = rd_ptr = 0, cnt = 0, starve counter = 0.
  - wb_buf_empty = 1, wb_buf_vpu_rdy = 1, vpu_rtu_gpr_wb_req = 0, wb_buf_starve = 0.
  - Index/data storage is not reset. Outputs read as don't-care while req = 0.
- Push:
  - Occurs when vpu_wb_vld && wb_buf_vpu_rdy. Entry is written at wr_ptr; wr_ptr increments modulo DEPTH.
  - wb_buf_vpu_rdy = (cnt != DEPTH). It depends only on registered cnt; there is no grant-to-rdy combinational path.
  - When full, a push is refused even if a pop occurs the same cycle.
  - vpu_wb_vld while rdy = 0: ignored. Upstream holds vld, index and data until rdy.
- Pop:
  - vpu_rtu_gpr_wb_req = !wb_buf_empty. Index/data are driven from entry[rd_ptr].
  - Pop occurs when req && grnt; rd_ptr increments modulo DEPTH.
  - Grant without a request has no effect.
- Count:
  - Push only: cnt + 1. Pop only: cnt - 1. Push and pop together: cnt unchanged, both pointers advance.
  - wb_buf_empty = (cnt == 0), registered alongside cnt.
- Latency: a push in cycle N is visible as req in cycle N+1 at the earliest. Order is strictly FIFO.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble. A full-to-empty drain of DEPTH pops takes DEPTH granted cycles.
- Starvation counter:
  - Increments each cycle with req && !grnt, saturating at STARVE_LIMIT.
  - Clears to 0 on any pop, or when the buffer is empty.
  - wb_buf_starve is registered: 1 in the cycle after the counter reaches STARVE_LIMIT. It deasserts the cycle after the clearing pop.
- Reset mid-operation: all pending entries are discarded immediately (asynchronous). req falls with cpurst without waiting for a clock edge.

Optional Feature:
- Macro: AQ_RTU_VPU_WB_BYPASS_EN.
- Defined:
  - When cnt == 0 and vpu_wb_vld, req asserts in the same cycle with the input index/data passed combinationally.
  - If grnt is also 1, nothing is written and cnt stays 0.
  - If grnt is 0, the input is pushed normally and presented from storage from the next cycle.
  - wb_buf_empty still reflects stored entries only.
- Undefined: minimum push-to-req latency is 1 cycle, as described above.

Test Plan:
- Reset then single push (index 6'h0A, data 64'h1234) with grnt held 1 -> req = 1 in the next cycle with 0A/1234; cnt goes 1 then 0; empty returns to 1 one cycle after the pop.
- grnt = 0 while four pushes arrive (indices 1,2,3,4) -> cnt = 4, rdy = 0; a fifth vld is ignored; with grnt = 1 the pops emerge in order 1,2,3,4 over 4 cycles, then empty = 1.
- Full buffer with simultaneous pop and push attempt -> the push is refused (rdy = 0); cnt = 3 after the cycle.
- cnt = 2 with push and pop in the same cycle, repeated 10 cycles, then a drain -> cnt stays 2 throughout; the pointers wrap past 3→0 more than once; output order is preserved.
- One entry held with grnt = 0 for 8 cycles -> wb_buf_starve = 1 on cycle 9; grant on cycle 10 pops the entry; starve = 0 on cycle 11.
- cpurst asserted mid-drain with cnt = 3 -> req, cnt and starve drop to 0 asynchronously; the first post-reset push is output correctly. With AQ_RTU_VPU_WB_BYPASS_EN: a push into the empty buffer with grnt = 1 gives req in the same cycle and cnt stays 0.

Source files
------------

// File: rtl/aq_rtu_vpu_wb_buf.sv
// ---------------------------------------------------------------------------
// aq_rtu_vpu_wb_buf
//
// FIFO between VPU GPR result generation and RTU writeback port0. VPU results
// are parked here while port0 is busy with Rbus writebacks. They are then
// presented to port0 in strict FIFO order. A starvation flag reports a head
// entry that has been denied for STARVE_LIMIT consecutive cycles, so that
// upstream can throttle Rbus issue.
//
// Optional feature macro: AQ_RTU_VPU_WB_BYPASS_EN
//   When the macro is defined, an empty buffer forwards a valid VPU input
//   straight to port0 in the same cycle. If port0 grants that cycle, nothing
//   is stored. When the macro is undefined, every result goes through storage.
//
// Ports:
//   forever_cpuclk        in   core clock
//   cpurst                in   asynchronous active-high reset
//   vpu_wb_vld            in   VPU presents a GPR writeback
//   vpu_wb_index[5:0]     in   destination register index
//   vpu_wb_data[63:0]     in   writeback data
//   wb_buf_vpu_rdy        out  buffer accepts a push this cycle
//   rtu_vpu_gpr_wb_grnt   in   port0 grant to VPU
//   vpu_rtu_gpr_wb_req    out  head entry requests port0
//   vpu_rtu_gpr_wb_index  out  head index
//   vpu_rtu_gpr_wb_data   out  head data
//   wb_buf_cnt[PTR_W:0]   out  current occupancy
//   wb_buf_empty          out  no stored entries
//   wb_buf_starve         out  head starved for STARVE_LIMIT cycles
// ---------------------------------------------------------------------------
module aq_rtu_vpu_wb_buf #(
  parameter int DEPTH        = 4,
  parameter int PTR_W        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             vpu_wb_vld,
  input  logic [5:0]       vpu_wb_index,
  input  logic [63:0]      vpu_wb_data,
  output logic             wb_buf_vpu_rdy,
  input  logic             rtu_vpu_gpr_wb_grnt,
  output logic             vpu_rtu_gpr_wb_req,
  output logic [5:0]       vpu_rtu_gpr_wb_index,
  output logic [63:0]      vpu_rtu_gpr_wb_data,
  output logic [PTR_W:0]   wb_buf_cnt,
  output logic             wb_buf_empty,
  output logic             wb_buf_starve
);

  localparam int IDX_W  = 6;
  localparam int DATA_W = 64;
  localparam int SC_W   = 8;

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [SC_W-1:0]  SC_LIMIT = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);

  // Entry storage (not reset; contents are meaningless while req is low)
  logic [IDX_W-1:0]  r_idx_mem  [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];

  // Control state
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_cnt;
  logic              r_empty;
  logic [SC_W-1:0]   r_sc;
  logic              r_starve;

  logic              w_push;
  logic              w_pop;
  logic [PTR_W:0]    w_cnt_nxt;
  logic [SC_W-1:0]   w_sc_nxt;

  // rdy depends only on the registered count. A pop in the same cycle does
  // not open a slot for a push, so grant has no path to rdy.
  assign wb_buf_vpu_rdy = (r_cnt != CNT_FULL);

  // Only stored entries can be popped
  assign w_pop = ~r_empty & rtu_vpu_gpr_wb_grnt;

`ifdef AQ_RTU_VPU_WB_BYPASS_EN
  logic w_byp;
  // Gated with cpurst so that req still falls immediately during reset
  assign w_byp                = r_empty & vpu_wb_vld & ~cpurst;
  // A bypassed transfer that is granted never touches storage
  assign w_push               = vpu_wb_vld & wb_buf_vpu_rdy & ~(w_byp & rtu_vpu_gpr_wb_grnt);
  assign vpu_rtu_gpr_wb_req   = ~r_empty | w_byp;
  assign vpu_rtu_gpr_wb_index = w_byp ? vpu_wb_index : r_idx_mem[r_rd_ptr];
  assign vpu_rtu_gpr_wb_data  = w_byp ? vpu_wb_data  : r_data_mem[r_rd_ptr];
`else
  assign w_push               = vpu_wb_vld & wb_buf_vpu_rdy;
  assign vpu_rtu_gpr_wb_req   = ~r_empty;
  assign vpu_rtu_gpr_wb_index = r_idx_mem[r_rd_ptr];
  assign vpu_rtu_gpr_wb_data  = r_data_mem[r_rd_ptr];
`endif

  assign wb_buf_cnt    = r_cnt;
  assign wb_buf_empty  = r_empty;
  assign wb_buf_starve = r_starve;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CNT_ONE;
      2'b01:   w_cnt_nxt = r_cnt - CNT_ONE;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // The starve count tracks consecutive denied cycles of a stored head. It
  // restarts on every pop and whenever nothing is stored.
  always_comb begin
    w_sc_nxt = r_sc;
    if (w_pop || r_empty) begin
      w_sc_nxt = '0;
    end else if (!rtu_vpu_gpr_wb_grnt && (r_sc != SC_LIMIT)) begin
      w_sc_nxt = r_sc + SC_ONE;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (w_push) begin
      r_idx_mem[r_wr_ptr]  <= vpu_wb_index;
      r_data_mem[r_wr_ptr] <= vpu_wb_data;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_empty  <= 1'b1;
      r_sc     <= '0;
      r_starve <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_cnt    <= w_cnt_nxt;
      r_empty  <= (w_cnt_nxt == '0);
      r_sc     <= w_sc_nxt;
      // The flag is registered from the next count value. It rises in the
      // cycle the count reaches the limit and falls in the cycle after a pop.
      r_starve <= (w_sc_nxt == SC_LIMIT);
    end
  end

endmodule

// File: tb/tb_aq_rtu_vpu_wb_buf.sv
module tb_aq_rtu_vpu_wb_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [5:0]  idx = '0;
  logic [63:0] dat = '0;
  logic        grnt = 1'b0;
  logic        rdy;
  logic        req;
  logic [5:0]  oidx;
  logic [63:0] odat;
  logic [2:0]  cnt;
  logic        empty;
  logic        starve;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aq_rtu_vpu_wb_buf #(.DEPTH(4), .PTR_W(2), .STARVE_LIMIT(8)) dut (
    .forever_cpuclk       (clk),
    .cpurst               (rst),
    .vpu_wb_vld           (vld),
    .vpu_wb_index         (idx),
    .vpu_wb_data          (dat),
    .wb_buf_vpu_rdy       (rdy),
    .rtu_vpu_gpr_wb_grnt  (grnt),
    .vpu_rtu_gpr_wb_req   (req),
    .vpu_rtu_gpr_wb_index (oidx),
    .vpu_rtu_gpr_wb_data  (odat),
    .wb_buf_cnt           (cnt),
    .wb_buf_empty         (empty),
    .wb_buf_starve        (starve)
  );

  typedef struct {
    string       name;
    logic        vld;
    logic [5:0]  idx;
    logic [63:0] dat;
    logic        grnt;
    logic        rdy;
    logic        req;
    logic [5:0]  eidx;
    logic [63:0] edat;
    logic [2:0]  cnt;
    logic        empty;
    logic        starve;
  } tv_t;

  tv_t tv[$];

  function automatic logic [63:0] dv(input logic [5:0] i);
    return 64'hC0DE_0000_0000_0000 | {58'd0, i};
  endfunction

  function automatic void add(input string nm, input logic v, input logic [5:0] i,
                              input logic [63:0] d, input logic g, input logic erdy,
                              input logic ereq, input logic [5:0] ei, input logic [63:0] ed,
                              input logic [2:0] ec, input logic ee, input logic es);
    tv_t t;
    t.name = nm; t.vld = v; t.idx = i; t.dat = d; t.grnt = g;
    t.rdy = erdy; t.req = ereq; t.eidx = ei; t.edat = ed;
    t.cnt = ec; t.empty = ee; t.starve = es;
    tv.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Called at posedge+1: drive, check the current-cycle outputs, then clock.
  task automatic apply(input tv_t t);
    vld = t.vld; idx = t.idx; dat = t.dat; grnt = t.grnt;
    #1;
    chk({t.name, ".rdy"},    64'(rdy),    64'(t.rdy));
    chk({t.name, ".req"},    64'(req),    64'(t.req));
    chk({t.name, ".cnt"},    64'(cnt),    64'(t.cnt));
    chk({t.name, ".empty"},  64'(empty),  64'(t.empty));
    chk({t.name, ".starve"}, 64'(starve), 64'(t.starve));
    if (t.req) begin
      chk({t.name, ".index"}, 64'(oidx), 64'(t.eidx));
      chk({t.name, ".data"},  odat,      t.edat);
    end
    @(posedge clk); #1;
  endtask

  task automatic step(input logic v, input logic [5:0] i, input logic [63:0] d, input logic g);
    vld = v; idx = i; dat = d; grnt = g;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdy",    64'(rdy),    64'd1);
    chk("rst.req",    64'(req),    64'd0);
    chk("rst.cnt",    64'(cnt),    64'd0);
    chk("rst.empty",  64'(empty),  64'd1);
    chk("rst.starve", 64'(starve), 64'd0);
    rst = 1'b0;

`ifndef AQ_RTU_VPU_WB_BYPASS_EN
    // single push / pop
    add("t1_idle",  0, 6'h00, 64'h0,    0, 1, 0, 6'h00, 64'h0,    0, 1, 0);
    add("t1_push",  1, 6'h0A, 64'h1234, 1, 1, 0, 6'h00, 64'h0,    0, 1, 0);
    add("t1_req",   0, 6'h00, 64'h0,    1, 1, 1, 6'h0A, 64'h1234, 1, 0, 0);
    add("t1_empty", 0, 6'h00, 64'h0,    1, 1, 0, 6'h00, 64'h0,    0, 1, 0);
    // fill to full, fifth vld ignored, drain in order
    add("t2_push1", 1, 6'd1, dv(6'd1), 0, 1, 0, 6'd0, 64'h0,     0, 1, 0);
    add("t2_push2", 1, 6'd2, dv(6'd2), 0, 1, 1, 6'd1, dv(6'd1),  1, 0, 0);
    add("t2_push3", 1, 6'd3, dv(6'd3), 0, 1, 1, 6'd1, dv(6'd1),  2, 0, 0);
    add("t2_push4", 1, 6'd4, dv(6'd4), 0, 1, 1, 6'd1, dv(6'd1),  3, 0, 0);
    add("t2_full",  1, 6'd5, dv(6'd5), 0, 0, 1, 6'd1, dv(6'd1),  4, 0, 0);
    add("t2_pop1",  0, 6'd0, 64'h0,    1, 0, 1, 6'd1, dv(6'd1),  4, 0, 0);
    add("t2_pop2",  0, 6'd0, 64'h0,    1, 1, 1, 6'd2, dv(6'd2),  3, 0, 0);
    add("t2_pop3",  0, 6'd0, 64'h0,    1, 1, 1, 6'd3, dv(6'd3),  2, 0, 0);
    add("t2_pop4",  0, 6'd0, 64'h0,    1, 1, 1, 6'd4, dv(6'd4),  1, 0, 0);
    add("t2_empty", 0, 6'd0, 64'h0,    1, 1, 0, 6'd0, 64'h0,     0, 1, 0);
    // full with simultaneous pop and push attempt
    add("t3_p1",    1, 6'd11, dv(6'd11), 0, 1, 0, 6'd0,  64'h0,     0, 1, 0);
    add("t3_p2",    1, 6'd12, dv(6'd12), 0, 1, 1, 6'd11, dv(6'd11), 1, 0, 0);
    add("t3_p3",    1, 6'd13, dv(6'd13), 0, 1, 1, 6'd11, dv(6'd11), 2, 0, 0);
    add("t3_p4",    1, 6'd14, dv(6'd14), 0, 1, 1, 6'd11, dv(6'd11), 3, 0, 0);
    add("t3_pp",    1, 6'd15, dv(6'd15), 1, 0, 1, 6'd11, dv(6'd11), 4, 0, 0);
    add("t3_after", 0, 6'd0,  64'h0,     0, 1, 1, 6'd12, dv(6'd12), 3, 0, 0);
    add("t3_d1",    0, 6'd0,  64'h0,     1, 1, 1, 6'd12, dv(6'd12), 3, 0, 0);
    add("t3_d2",    0, 6'd0,  64'h0,     1, 1, 1, 6'd13, dv(6'd13), 2, 0, 0);
    add("t3_d3",    0, 6'd0,  64'h0,     1, 1, 1, 6'd14, dv(6'd14), 1, 0, 0);
    add("t3_empty", 0, 6'd0,  64'h0,     0, 1, 0, 6'd0,  64'h0,     0, 1, 0);
    // steady cnt=2 with push+pop each cycle, pointers wrap repeatedly
    add("t4_p1",    1, 6'd20, dv(6'd20), 0, 1, 0, 6'd0,  64'h0,     0, 1, 0);
    add("t4_p2",    1, 6'd21, dv(6'd21), 0, 1, 1, 6'd20, dv(6'd20), 1, 0, 0);
    for (int k = 0; k < 10; k++)
      add("t4_pp", 1, 6'(22 + k), dv(6'(22 + k)), 1, 1, 1, 6'(20 + k), dv(6'(20 + k)), 2, 0, 0);
    add("t4_d1",    0, 6'd0,  64'h0,     1, 1, 1, 6'd30, dv(6'd30), 2, 0, 0);
    add("t4_d2",    0, 6'd0,  64'h0,     1, 1, 1, 6'd31, dv(6'd31), 1, 0, 0);
    add("t4_empty", 0, 6'd0,  64'h0,     0, 1, 0, 6'd0,  64'h0,     0, 1, 0);
    // starvation: 8 denied cycles raise the flag, the pop clears it
    add("t5_push",  1, 6'h2A, dv(6'h2A), 0, 1, 0, 6'd0,  64'h0,     0, 1, 0);
    for (int k = 0; k < 8; k++)
      add("t5_hold", 0, 6'd0, 64'h0, 0, 1, 1, 6'h2A, dv(6'h2A), 1, 0, 0);
    add("t5_on",    0, 6'd0,  64'h0,     0, 1, 1, 6'h2A, dv(6'h2A), 1, 0, 1);
    add("t5_pop",   0, 6'd0,  64'h0,     1, 1, 1, 6'h2A, dv(6'h2A), 1, 0, 1);
    add("t5_off",   0, 6'd0,  64'h0,     0, 1, 0, 6'd0,  64'h0,     0, 1, 0);
`else
    // same-cycle bypass into an empty buffer
    add("b_grant",  1, 6'd5, dv(6'd5), 1, 1, 1, 6'd5, dv(6'd5), 0, 1, 0);
    add("b_none",   0, 6'd0, 64'h0,    1, 1, 0, 6'd0, 64'h0,    0, 1, 0);
    add("b_deny",   1, 6'd6, dv(6'd6), 0, 1, 1, 6'd6, dv(6'd6), 0, 1, 0);
    add("b_stored", 0, 6'd0, 64'h0,    0, 1, 1, 6'd6, dv(6'd6), 1, 0, 0);
    add("b_pop",    0, 6'd0, 64'h0,    1, 1, 1, 6'd6, dv(6'd6), 1, 0, 0);
    add("b_empty",  0, 6'd0, 64'h0,    0, 1, 0, 6'd0, 64'h0,    0, 1, 0);
`endif

    for (int n = 0; n < tv.size(); n++) apply(tv[n]);

    // asynchronous reset with three entries pending and starve raised
    step(1, 6'h31, dv(6'h31), 0);
    step(1, 6'h32, dv(6'h32), 0);
    step(1, 6'h33, dv(6'h33), 0);
    for (int k = 0; k < 10; k++) step(0, 6'd0, 64'h0, 0);
    #1;
    chk("t6_pre.cnt",    64'(cnt),    64'd3);
    chk("t6_pre.starve", 64'(starve), 64'd1);
    chk("t6_pre.req",    64'(req),    64'd1);
    grnt = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst.req",    64'(req),    64'd0);
    chk("t6_rst.cnt",    64'(cnt),    64'd0);
    chk("t6_rst.starve", 64'(starve), 64'd0);
    chk("t6_rst.empty",  64'(empty),  64'd1);
    chk("t6_rst.rdy",    64'(rdy),    64'd1);
    grnt = 1'b0;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    step(1, 6'h3F, dv(6'h3F), 0);
    vld = 1'b0;
    #1;
    chk("t6_post.req",   64'(req),   64'd1);
    chk("t6_post.index", 64'(oidx),  64'h3F);
    chk("t6_post.data",  odat,       dv(6'h3F));
    chk("t6_post.cnt",   64'(cnt),   64'd1);
    step(0, 6'd0, 64'h0, 1);
    grnt = 1'b0;
    #1;
    chk("t6_drain.empty", 64'(empty), 64'd1);
    chk("t6_drain.req",   64'(req),   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
